// File: rtl/stack_op_sequencer_pkg.sv
// Shared types for the PC save/restore stack sequencer: op codes, FSM states,
// stack page placement and the small SP/PCS arithmetic helpers.
package stack_op_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_PUSH_PC    = 2'd0,
    OP_POP_PC     = 2'd1,
    OP_POP_PC_INC = 2'd2
  } stack_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_A0   = 3'd1,
    ST_A1   = 3'd2,
    ST_A2   = 3'd3,
    ST_FIN  = 3'd4
  } seq_state_t;

  // Upper RAM address bits above the 8-bit SP; the stack lives in page 0.
  localparam logic [15:0] STACK_PAGE = 16'h0000;

  localparam logic [7:0] SP_INC1 = 8'h01;
  localparam logic [7:0] SP_INC2 = 8'h02;
  localparam logic [7:0] SP_INC3 = 8'h03;
  localparam logic [7:0] SP_DEC1 = 8'hFF;
  localparam logic [7:0] SP_DEC2 = 8'hFE;
  localparam logic [7:0] SP_DEC3 = 8'hFD;

  // 8-bit modulo add keeps every stack access inside the 256-nibble page.
  function automatic logic [7:0] sp_step(input logic [7:0] sp, input logic [7:0] delta);
    return sp + delta;
  endfunction

  // RETS bumps only the low byte; a carry out of PCS is dropped, never fed to PCP.
  function automatic logic [7:0] pcs_adjust(input logic [7:0] pcs, input logic inc);
    return inc ? pcs + 8'd1 : pcs;
  endfunction

endpackage

// File: rtl/stack_op_sequencer.sv
// Sequences three nibble RAM accesses to push or pop the PC around SP, then
// hands the rebuilt PC and updated SP back to the register file.
module stack_op_sequencer
  import stack_op_sequencer_pkg::*;
#(
  parameter int RAM_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [12:0]           pc_in,
  input  logic [7:0]            sp_in,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic                  ram_wr,
  output logic [3:0]            ram_wdata,
  input  logic [3:0]            ram_rdata,
  output logic                  busy,
  output logic                  done,
  output logic [12:0]           pc_out,
  output logic [7:0]            sp_out,
  output logic                  sp_we
);

  seq_state_t            state_q;
  stack_op_t             op_q;
  logic                  bank_q;
  logic [7:0]            sp_q;
  logic [11:0]           cap_q;
  logic [RAM_ADDR_W-1:0] ram_addr_q;
  logic                  ram_wr_q;
  logic [3:0]            ram_wdata_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  sp_we_q;
  logic [12:0]           pc_out_q;
  logic [7:0]            sp_out_q;

  logic [7:0]            seq_addr_d;
  logic [3:0]            wdata_d;
  logic                  wr_d;
  logic                  start_push;
  logic                  op_push;
  logic                  op_inc;

  function automatic logic [RAM_ADDR_W-1:0] page_addr(input logic [7:0] a);
    return {STACK_PAGE[RAM_ADDR_W-9:0], a};
  endfunction

  assign start_push = (op == OP_PUSH_PC);
  assign op_push    = (op_q == OP_PUSH_PC);
  assign op_inc     = (op_q == OP_POP_PC_INC);

  // Address/data for the access that the next clk_en edge will present.
  always_comb begin
    seq_addr_d = sp_q;
    wdata_d    = 4'h0;
    wr_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_push) begin
          seq_addr_d = sp_step(sp_in, SP_DEC1);
          wdata_d    = pc_in[11:8];
          wr_d       = 1'b1;
        end else begin
          seq_addr_d = sp_in;
        end
      end
      ST_A0: begin
        if (op_push) begin
          seq_addr_d = sp_step(sp_q, SP_DEC2);
          wdata_d    = cap_q[7:4];
          wr_d       = 1'b1;
        end else begin
          seq_addr_d = sp_step(sp_q, SP_INC1);
        end
      end
      ST_A1: begin
        if (op_push) begin
          seq_addr_d = sp_step(sp_q, SP_DEC3);
          wdata_d    = cap_q[3:0];
          wr_d       = 1'b1;
        end else begin
          seq_addr_d = sp_step(sp_q, SP_INC2);
        end
      end
      default: begin
        seq_addr_d = sp_q;
        wdata_d    = 4'h0;
        wr_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_PUSH_PC;
      bank_q      <= 1'b0;
      sp_q        <= 8'h00;
      cap_q       <= 12'h000;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_wdata_q <= 4'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sp_we_q     <= 1'b0;
      pc_out_q    <= 13'h0000;
      sp_out_q    <= 8'h00;
    end else begin
      // Completion strobes last one clk even when clk_en is sparse.
      done_q  <= 1'b0;
      sp_we_q <= 1'b0;
      if (clk_en) begin
        unique case (state_q)
          ST_IDLE: begin
            if (start) begin
              op_q        <= stack_op_t'(op);
              bank_q      <= pc_in[12];
              sp_q        <= sp_in;
              cap_q       <= pc_in[11:0];
              ram_addr_q  <= page_addr(seq_addr_d);
              ram_wr_q    <= wr_d;
              ram_wdata_q <= wdata_d;
              busy_q      <= 1'b1;
              state_q     <= ST_A0;
            end
          end
          ST_A0: begin
            ram_addr_q  <= page_addr(seq_addr_d);
            ram_wr_q    <= wr_d;
            ram_wdata_q <= wdata_d;
            state_q     <= ST_A1;
          end
          ST_A1: begin
            ram_addr_q  <= page_addr(seq_addr_d);
            ram_wr_q    <= wr_d;
            ram_wdata_q <= wdata_d;
            if (!op_push) cap_q[3:0] <= ram_rdata;
            state_q     <= ST_A2;
          end
          ST_A2: begin
            ram_wr_q <= 1'b0;
            if (!op_push) cap_q[7:4] <= ram_rdata;
            state_q  <= ST_FIN;
          end
          ST_FIN: begin
            if (op_push) begin
              pc_out_q <= {bank_q, cap_q};
              sp_out_q <= sp_step(sp_q, SP_DEC3);
            end else begin
              // PCP arrives on this step; it is merged straight into the result.
              pc_out_q <= {bank_q, ram_rdata, pcs_adjust(cap_q[7:0], op_inc)};
              sp_out_q <= sp_step(sp_q, SP_INC3);
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sp_we_q <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: begin
            ram_wr_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_wr    = ram_wr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sp_we     = sp_we_q;
  assign pc_out    = pc_out_q;
  assign sp_out    = sp_out_q;

endmodule
